// File: rtl/controle_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes, ALU selects
// and the Moore output decode. STEP_EN adds the PAUSE single-step state.
package controle_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
`ifdef STEP_EN
      , PAUSE = 3'd6
`endif
   } estado_t;

   localparam logic [2:0] OP_ADDI = 3'b000;
   localparam logic [2:0] OP_SUBI = 3'b001;
   localparam logic [2:0] OP_ANDI = 3'b010;
   localparam logic [2:0] OP_ORI  = 3'b011;
   localparam logic [2:0] OP_LW   = 3'b100;
   localparam logic [2:0] OP_SW   = 3'b101;
   localparam logic [2:0] OP_CLR  = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;

   typedef struct packed {
      logic       irWr;
      logic       pcEsc;
      logic       memEn;
      logic       memOp;
      logic       clear;
      logic       regEsc;
      logic       memtoReg;
      logic       fonteEscrita;
      logic       stop;
      logic [3:0] aluCode;
   } saidas_t;

   function automatic logic [3:0] aluDe(input logic [2:0] op);
      logic [3:0] a;
      case (op)
         OP_SUBI: a = ALU_SUB;
         OP_ANDI: a = ALU_AND;
         OP_ORI:  a = ALU_OR;
         default: a = ALU_ADD;
      endcase
      return a;
   endfunction

   // Outputs are a pure function of state and latched opcode.
   function automatic saidas_t decodifica(input estado_t st, input logic [2:0] op);
      saidas_t s;
      s = '0;
      case (st)
         FETCH: begin
            s.irWr  = 1'b1;
            s.memEn = 1'b1;
            s.stop  = 1'b1;
         end
         EXEC: begin
            s.stop    = 1'b1;
            s.aluCode = aluDe(op);
         end
         MEM: begin
            s.stop  = 1'b1;
            s.memEn = 1'b1;
            s.memOp = (op == OP_SW);
            s.clear = (op == OP_CLR);
         end
         WB: begin
            s.pcEsc = 1'b1;
            if (!op[2]) begin
               s.regEsc  = 1'b1;
               s.aluCode = aluDe(op);
            end else if (op == OP_LW) begin
               s.regEsc       = 1'b1;
               s.memtoReg     = 1'b1;
               s.fonteEscrita = 1'b1;
            end
         end
         default: s.stop = 1'b1;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/contador_espera.sv
// Counts consecutive memory-wait cycles and flags when the timeout limit is reached.
module contador_espera #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic Clk,
   input  logic Rst_n,
   input  logic Clear,
   input  logic Enable,
   output logic Limit
);

   localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [W-1:0] LIMITE = W'(MEM_TIMEOUT - 1);

   logic [W-1:0] contagem;

   // Saturates at the limit so a stalled count can never wrap back to zero.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)
         contagem <= '0;
      else if (Clear)
         contagem <= '0;
      else if (Enable && contagem != LIMITE)
         contagem <= contagem + W'(1);
   end

   assign Limit = (contagem == LIMITE);

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle Moore control unit: FETCH/DECODE/EXEC/MEM/WB/HALT with memory timeout.
// Define STEP_EN to add the Step input and the PAUSE state after every writeback.
module controle_multiciclo
   import controle_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             Clk,
   input  logic             Rst_n,
`ifdef STEP_EN
   input  logic             Step,
`endif
   input  logic [2:0]       OpCode,
   input  logic             MemReady,
   output logic             IRWr,
   output logic             PCEsc,
   output logic             MemEn,
   output logic             MemOp,
   output logic             Clear,
   output logic             RegEsc,
   output logic             MemtoReg,
   output logic             FonteEscrita,
   output logic [3:0]       ALUCode,
   output logic             Stop,
   output logic             Erro,
   output logic [2:0]       Estado,
   output logic [CNT_W-1:0] InstrCount
);

   estado_t          estadoReg, estadoNext;
   logic [2:0]       opReg, opNext;
   logic             erroReg, erroNext;
   logic [CNT_W-1:0] contReg;
   saidas_t          saidasReg;
   logic             emEspera, limiteEspera;

   assign emEspera = (estadoReg == FETCH) || (estadoReg == MEM);

   // Cleared in every non-waiting state, so it is zero on entry to FETCH/MEM.
   contador_espera #(.MEM_TIMEOUT(MEM_TIMEOUT)) uEspera (
      .Clk    (Clk),
      .Rst_n  (Rst_n),
      .Clear  (!emEspera),
      .Enable (emEspera && !MemReady),
      .Limit  (limiteEspera)
   );

   always_comb begin
      estadoNext = estadoReg;
      opNext     = opReg;
      erroNext   = erroReg;
      case (estadoReg)
         FETCH, MEM: begin
            if (MemReady) begin
               estadoNext = (estadoReg == FETCH) ? DECODE : WB;
            end else if (limiteEspera) begin
               estadoNext = HALT;
               erroNext   = 1'b1;
            end
         end
         DECODE: begin
            opNext = OpCode;
            if (OpCode == OP_HALT)
               estadoNext = HALT;
            else if (OpCode == OP_LW || OpCode == OP_SW || OpCode == OP_CLR)
               estadoNext = MEM;
            else
               estadoNext = EXEC;
         end
         EXEC: estadoNext = WB;
`ifdef STEP_EN
         WB:    estadoNext = PAUSE;
         PAUSE: if (Step) estadoNext = FETCH;
`else
         WB:    estadoNext = FETCH;
`endif
         HALT:  estadoNext = HALT;
         default: estadoNext = FETCH;
      endcase
   end

   // Output register is loaded with the decode of the state being entered,
   // so it always matches estadoReg; its reset value is the FETCH decode.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         estadoReg <= FETCH;
         opReg     <= OP_ADDI;
         erroReg   <= 1'b0;
         contReg   <= '0;
         saidasReg <= decodifica(FETCH, OP_ADDI);
      end else begin
         estadoReg <= estadoNext;
         opReg     <= opNext;
         erroReg   <= erroNext;
         saidasReg <= decodifica(estadoNext, opNext);
         if (estadoReg == WB)
            contReg <= contReg + CNT_W'(1);
      end
   end

   // Reset blanks every strobe immediately; FETCH strobes appear right at release.
   assign IRWr         = saidasReg.irWr & Rst_n;
   assign PCEsc        = saidasReg.pcEsc & Rst_n;
   assign MemEn        = saidasReg.memEn & Rst_n;
   assign MemOp        = saidasReg.memOp & Rst_n;
   assign Clear        = saidasReg.clear & Rst_n;
   assign RegEsc       = saidasReg.regEsc & Rst_n;
   assign MemtoReg     = saidasReg.memtoReg & Rst_n;
   assign FonteEscrita = saidasReg.fonteEscrita & Rst_n;
   assign Stop         = saidasReg.stop & Rst_n;
   assign ALUCode      = saidasReg.aluCode & {4{Rst_n}};
   assign Erro         = erroReg;
   assign Estado       = estadoReg;
   assign InstrCount   = contReg;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: per-cycle expectations queued by the
// stimulus, checked on the falling edge by an independent monitor.
module tb_controle_multiciclo;

   localparam int CNT_W = 3;

   // Bit order: IRWr PCEsc MemEn MemOp Clear RegEsc MemtoReg FonteEscrita Stop | ALUCode
   localparam logic [12:0] E_ZERO   = 13'b000000000_0000;
   localparam logic [12:0] E_FETCH  = 13'b101000001_0000;
   localparam logic [12:0] E_STOP   = 13'b000000001_0000;
   localparam logic [12:0] E_MEMLW  = 13'b001000001_0000;
   localparam logic [12:0] E_MEMSW  = 13'b001100001_0000;
   localparam logic [12:0] E_MEMCLR = 13'b001010001_0000;
   localparam logic [12:0] E_WBLW   = 13'b010001110_0000;
   localparam logic [12:0] E_WBNONE = 13'b010000000_0000;
   localparam logic [8:0]  EXEC_HI  = 9'b000000001;
   localparam logic [8:0]  WBALU_HI = 9'b010001000;

   logic             Clk = 1'b0;
   logic             Rst_n = 1'b0;
   logic [2:0]       OpCode = 3'b000;
   logic             MemReady = 1'b0;
`ifdef STEP_EN
   logic             Step = 1'b0;
`endif
   logic             IRWr, PCEsc, MemEn, MemOp, Clear, RegEsc, MemtoReg, FonteEscrita, Stop, Erro;
   logic [3:0]       ALUCode;
   logic [2:0]       Estado;
   logic [CNT_W-1:0] InstrCount;

   controle_multiciclo #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
`ifdef STEP_EN
      .Step(Step),
`endif
      .OpCode(OpCode), .MemReady(MemReady),
      .IRWr(IRWr), .PCEsc(PCEsc), .MemEn(MemEn), .MemOp(MemOp), .Clear(Clear),
      .RegEsc(RegEsc), .MemtoReg(MemtoReg), .FonteEscrita(FonteEscrita),
      .ALUCode(ALUCode), .Stop(Stop), .Erro(Erro), .Estado(Estado),
      .InstrCount(InstrCount)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int               idx;
      logic [2:0]       st;
      logic [12:0]      outs;
      logic [CNT_W-1:0] cnt;
      logic             err;
   } esperado_t;

   esperado_t fila[$];
   int checks = 0;
   int failures = 0;
   int cycleNo = 0;
   int expCnt = 0;
   logic expErr = 1'b0;

   logic [12:0] saidas;
   assign saidas = {IRWr, PCEsc, MemEn, MemOp, Clear, RegEsc, MemtoReg, FonteEscrita, Stop, ALUCode};

   // Monitor: the DUT presents a full output word every cycle.
   initial begin
      esperado_t e;
      forever begin
         @(negedge Clk);
         if (fila.size() > 0) begin
            e = fila.pop_front();
            checks++;
            if (Estado !== e.st) begin
               failures++;
               $display("FAIL estado cyc=%0d got=%0d exp=%0d", e.idx, Estado, e.st);
            end
            checks++;
            if (saidas !== e.outs) begin
               failures++;
               $display("FAIL strobes cyc=%0d st=%0d got=%b exp=%b", e.idx, e.st, saidas, e.outs);
            end
            checks++;
            if (InstrCount !== e.cnt) begin
               failures++;
               $display("FAIL instrcount cyc=%0d got=%0d exp=%0d", e.idx, InstrCount, e.cnt);
            end
            checks++;
            if (Erro !== e.err) begin
               failures++;
               $display("FAIL erro cyc=%0d got=%0d exp=%0d", e.idx, Erro, e.err);
            end
            $display("cyc=%0d estado=%0d strobes=%b cnt=%0d erro=%0d", e.idx, Estado, saidas, InstrCount, Erro);
         end
      end
   end

   task automatic cyc(input logic [2:0] op, input logic mr, input logic [2:0] st, input logic [12:0] outs);
      esperado_t e;
      OpCode   = op;
      MemReady = mr;
      e.idx = cycleNo; e.st = st; e.outs = outs; e.cnt = CNT_W'(expCnt); e.err = expErr;
      fila.push_back(e);
      cycleNo++;
      @(posedge Clk); #1;
   endtask

   task automatic rstCyc(input int n);
      esperado_t e;
      Rst_n  = 1'b0;
      expCnt = 0;
      expErr = 1'b0;
      for (int i = 0; i < n; i++) begin
         e.idx = cycleNo; e.st = 3'd0; e.outs = E_ZERO; e.cnt = '0; e.err = 1'b0;
         fila.push_back(e);
         cycleNo++;
         @(posedge Clk); #1;
      end
      Rst_n = 1'b1;
   endtask

   task automatic fetchPhase(input logic [2:0] op, input int waits);
      for (int i = 0; i < waits; i++) cyc(op, 1'b0, 3'd0, E_FETCH);
      cyc(op, 1'b1, 3'd0, E_FETCH);
      cyc(op, 1'b1, 3'd1, E_STOP);
   endtask

   task automatic afterWb(input logic [2:0] op);
      expCnt = (expCnt + 1) % (1 << CNT_W);
`ifdef STEP_EN
      Step = 1'b0;
      cyc(op, 1'b1, 3'd6, E_STOP);
      Step = 1'b1;
      cyc(op, 1'b1, 3'd6, E_STOP);
      Step = 1'b0;
`else
      OpCode = op;
`endif
   endtask

   task automatic aluInstr(input logic [2:0] op, input logic [3:0] alu, input int fw);
      fetchPhase(op, fw);
      cyc(op, 1'b1, 3'd2, {EXEC_HI, alu});
      cyc(op, 1'b1, 3'd4, {WBALU_HI, alu});
      afterWb(op);
   endtask

   task automatic memInstr(input logic [2:0] op, input int waits, input logic [12:0] memOuts, input logic [12:0] wbOuts);
      fetchPhase(op, 0);
      for (int i = 0; i < waits; i++) cyc(op, 1'b0, 3'd3, memOuts);
      cyc(op, 1'b1, 3'd3, memOuts);
      cyc(op, 1'b1, 3'd4, wbOuts);
      afterWb(op);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge Clk); #1;
      rstCyc(2);
      aluInstr(3'b000, 4'b0000, 0);          // ADDI
      aluInstr(3'b001, 4'b0001, 2);          // SUBI with fetch waits
      aluInstr(3'b010, 4'b0010, 0);          // ANDI
      aluInstr(3'b011, 4'b0011, 0);          // ORI
      memInstr(3'b100, 3, E_MEMLW, E_WBLW);  // LW, MEM lasts 4 cycles
      memInstr(3'b101, 1, E_MEMSW, E_WBNONE);
      memInstr(3'b110, 0, E_MEMCLR, E_WBNONE);
      aluInstr(3'b000, 4'b0000, 0);          // 8th instruction: count wraps to 0
      memInstr(3'b100, 14, E_MEMLW, E_WBLW); // ready on the limit cycle: no fault
      // Timeout: 15 MEM cycles without MemReady
      fetchPhase(3'b100, 0);
      for (int i = 0; i < 15; i++) cyc(3'b100, 1'b0, 3'd3, E_MEMLW);
      expErr = 1'b1;
      for (int i = 0; i < 3; i++) cyc(3'b100, 1'b1, 3'd5, E_STOP);
      rstCyc(1);
      // HALT opcode after one instruction, then reset mid-HALT
      aluInstr(3'b011, 4'b0011, 0);
      fetchPhase(3'b111, 0);
      for (int i = 0; i < 4; i++) cyc(3'b111, 1'b1, 3'd5, E_STOP);
      rstCyc(1);
      // Reset while waiting in MEM for a store
      fetchPhase(3'b101, 0);
      cyc(3'b101, 1'b0, 3'd3, E_MEMSW);
      cyc(3'b101, 1'b0, 3'd3, E_MEMSW);
      rstCyc(2);
      aluInstr(3'b001, 4'b0001, 0);
      repeat (3) @(posedge Clk);
      checks++;
      if (fila.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d exp=0", fila.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/controle_multiciclo.md
CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum consecutive cycles spent waiting for MemReady before a fault.
REQ-002 SHALL have parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 SHALL have port Clk  in  1: single clock, all state updates on its rising edge.
REQ-004 SHALL have port Rst_n  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port OpCode  in  3: instruction bits [31:29] from the datapath.
REQ-006 SHALL have port MemReady  in  1: memory completion for the instruction fetch or data access.
REQ-007 SHALL have port IRWr, PCEsc, MemEn, MemOp, Clear, RegEsc, MemtoReg, FonteEscrita  out  1 each: datapath strobes and selects.
REQ-008 SHALL have port ALUCode  out  4: ALU operation select.
REQ-009 SHALL have port Stop  out  1: PC frozen.
REQ-010 SHALL have port Erro  out  1: sticky timeout fault.
REQ-011 SHALL have port Estado  out  3: current state encoding.
REQ-012 SHALL have port InstrCount  out  CNT_W: number of retired instructions.

Function
REQ-013 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; outputs SHALL depend only on the state and the latched opcode.
REQ-014 In FETCH: IRWr=1 and MemEn=1; stay while MemReady=0; go to DECODE on MemReady=1.
REQ-015 In DECODE: latch OpCode into an internal opcode register; go to HALT on 111, to MEM on 100/101/110, otherwise to EXEC.
REQ-016 Opcode map: 000 ADDI (ALUCode 0000), 001 SUBI (0001), 010 ANDI (0010), 011 ORI (0011), 100 LW, 101 SW, 110 CLR, 111 HALT; ALUCode SHALL be 0000 whenever the state is not EXEC or WB.
REQ-017 In EXEC: drive ALUCode from the latched opcode; go to WB next cycle.
REQ-018 In MEM: MemEn=1; MemOp=1 only for SW; Clear=1 only for CLR; stay while MemReady=0; go to WB on MemReady=1.
REQ-019 In WB: PCEsc=1 for exactly one cycle; go to FETCH.
REQ-020 In WB for ALU ops: RegEsc=1, MemtoReg=0, FonteEscrita=0 (write accumulator).
REQ-021 In WB for LW: RegEsc=1, MemtoReg=1, FonteEscrita=1 (write Dest).
REQ-022 In WB for SW and CLR: RegEsc=0.
REQ-023 In HALT: Stop=1 and all strobes 0; remain in HALT until reset.
REQ-024 Stop SHALL also be 1 in every state except WB, so the PC advances only on PCEsc.
REQ-025 Latency with MemReady tied to 1: every non-HALT instruction SHALL take exactly 4 cycles; HALT SHALL be entered on the 3rd cycle.
REQ-026 Wait counter: clear on entry to FETCH/MEM; increment each cycle in FETCH/MEM with MemReady=0.
REQ-027 If MemReady=0 and the wait counter equals MEM_TIMEOUT-1, the FSM SHALL enter HALT and set Erro=1, which holds until reset.
REQ-028 If MemReady=1 arrives in the same cycle the timeout limit is reached, MemReady SHALL win and no fault SHALL occur.
REQ-029 InstrCount SHALL increment by 1 on each WB cycle and wrap from 2^CNT_W-1 to 0.

Reset
REQ-030 While Rst_n=0: state=FETCH, opcode register=000, wait counter=0, InstrCount=0, Erro=0, and every output forced to 0 (Estado=0).
REQ-031 Reset asserted mid-instruction (including in MEM or HALT) SHALL abort it with no further strobes; FETCH outputs SHALL appear in the first cycle after release.

Configuration
REQ-032 Macro STEP_EN defined: add input port Step (1 bit) and state PAUSE=6; WB SHALL go to PAUSE; PAUSE drives Stop=1 with all strobes 0 and goes to FETCH on the first sampled Step=1.
REQ-033 Macro STEP_EN undefined: no Step port, no PAUSE state; WB SHALL go directly to FETCH.

Structure
REQ-034 Package controle_pkg SHALL hold the state encodings, opcode constants and ALUCode constants.
REQ-035 The wait/timeout counter SHALL be a sub-module contador_espera (parameter MEM_TIMEOUT; inputs clear/enable; output limit flag).

Verification
REQ-036 ADDI with MemReady=1: Estado sequence 0,1,2,4,0; ALUCode=0000 in EXEC; RegEsc=1, FonteEscrita=0 in WB; InstrCount 0->1.
REQ-037 LW with MemReady low 3 cycles in MEM: MEM lasts 4 cycles; WB drives RegEsc=1, MemtoReg=1, FonteEscrita=1.
REQ-038 SW: MemEn=1, MemOp=1 throughout MEM; RegEsc=0 in WB; PCEsc pulses once.
REQ-039 MemReady held 0 in MEM with MEM_TIMEOUT=15: HALT entered after 15 MEM cycles with Erro=1; Erro stays 1 until Rst_n=0.
REQ-040 HALT opcode 111: Estado=5 on cycle 3, Stop=1 forever; Rst_n pulse mid-HALT returns Estado=0 with InstrCount=0.
REQ-041 STEP_EN build: after WB the FSM waits in PAUSE (Estado=6); a Step=1 pulse resumes FETCH next cycle.
